fixed_order_selector: RTL and testbench
=======================================

# fixed_order_selector

Controller that sequences the bank of fixed-predictor encoders (orders 0–4) over one audio block. It gates their shared enable, streams samples in under a valid/ready handshake, and flushes the encoder pipelines. It also accumulates the sum of absolute residuals per order and reports the order with the smallest sum. It sits between the block buffer and the fixed-encoder bank, ahead of the Rice parameter stage.

## Interface
Parameters:
- LATENCY, 8: enabled edges from sample presentation to its residual on the bank outputs; identical for all five orders.
- SUM_W, 32: width of each absolute-sum accumulator.

Ports:
- iClock  in  1  sole clock; all state changes on rising edge.
- iReset_n  in  1  asynchronous, active-low reset.
- iStart  in  1  start a block; sampled only in IDLE.
- iBlockSize  in  16  samples in block, latched on accepted iStart; 0 means 65536.
- iValid  in  1  sample present on the encoder bank's iSample (bank is driven directly by the source).
- oReady  out  1  sample accepted on a cycle with iValid && oReady.
- oEncEnable  out  1  shared iEnable for all five encoders.
- oEncReset  out  1  shared synchronous active-high iReset for all five encoders.
- iResidual0..iResidual4  in  16 each  signed residuals from orders 0–4.
- oBusy  out  1  high in every state except IDLE.
- oDone  out  1  one-cycle pulse when result valid.
- oBestOrder  out  3  selected order 0–4, held until next oDone.
- oBestSum  out  SUM_W  accumulated sum of the selected order, held until next oDone.

## Operation
- All outputs reset to 0. oBestOrder and oBestSum reset to 0. State resets to IDLE.
- States: IDLE, CLEAR, RUN, FLUSH, COMPARE, DONE.
- IDLE:
  - On iStart: latch the block size N, clear the five sums, the sample counter and the enable counter m, then go to CLEAR.
  - iStart in any other state is ignored.
- CLEAR (1 cycle): oEncReset=1, oEncEnable=0. Then go to RUN.
- RUN:
  - oReady=1 and oEncEnable = iValid.
  - Each accepted sample increments the sample counter.
  - After the N-th accept, go to FLUSH on that edge.
- FLUSH (exactly LATENCY+1 cycles): oReady=0, oEncEnable=1.
- Accumulation:
  - m counts enabled edges since CLEAR.
  - At enabled edge m ≥ LATENCY+2, the residual of sample n = m−LATENCY−2 is sampled.
  - Order k adds |iResidualk| only when n ≥ k, so warm-up samples are excluded.
- Absolute value: zero-extend to 17 bits, so |−32768| = 32768. Sums saturate at 2^SUM_W−1 and never wrap.
- Order k with N ≤ k has no valid residuals. Its sum is forced to all-ones, so it loses to any valid order. Order 0 is always valid.
- COMPARE (5 cycles): sequential scan of orders 0→4, keeping the running minimum with strict less-than. Ties resolve to the lower order.
- DONE (1 cycle): update oBestOrder/oBestSum, pulse oDone, return to IDLE.
- iValid is don't-care outside RUN.

## Timing
- The end-to-end timing follows from the state sequence:
  - iStart edge → CLEAR → first possible accept on the next cycle.
  - Last accept edge → LATENCY+1 FLUSH cycles → 5 COMPARE cycles → DONE.
  - oDone is therefore high in the cycle starting LATENCY+7 edges after the last accept, i.e. 15 edges at default.
- Minimum block time is N + LATENCY + 8 cycles at full input rate, plus one cycle in IDLE.
- Backpressure: oReady is never deasserted mid-RUN. Source stalls cost no extra flush.
- Asynchronous reset mid-block:
  - Immediate return to IDLE; all outputs go to 0.
  - The encoder bank is cleared by the next CLEAR, not by iReset_n.
- iStart on the same cycle as DONE is ignored; it is accepted only from IDLE.

## Structure
- Shared package `flac_fixed_pkg`:
  - state enum;
  - constants MAX_FIXED_ORDER=4, NUM_FIXED_ORDERS=5, SAMPLE_W=16;
  - function abs17 for the 17-bit absolute value.
- One sub-module, `abs_sum_accumulator`:
  - instantiated five times, parameterised by ORDER and SUM_W;
  - inputs: clear, enable, the sample index, and the residual;
  - behaviour: saturating add with warm-up gating.
- Controller FSM, counters and the compare scan stay in the top level.

## Test plan
1. N=16, all samples 0 → oDone with oBestOrder=0, oBestSum=0. oDone occurs 15 cycles after the last accept.
2. N=16, linear ramp 0,100,…,1500 → order 2 sum 0, order 1 sum 1500, order 0 sum 12000 → oBestOrder=2, oBestSum=0. Orders 3 and 4 are also 0, so the tie goes to the lower order and 2 is selected.
3. N=3, samples 5,5,5 → orders 3 and 4 forced to all-ones; order 1 sum 0 → oBestOrder=1.
4. N=8, iValid toggling 1/0 every cycle → exactly 8 accepts, oEncEnable high only on accept cycles in RUN. Result matches the stall-free run.
5. SUM_W=16, N=4, alternating ±32767 with −32768 → order 0 sum saturates at 65535. No wrap, and a smaller order is chosen.
6. iReset_n low during FLUSH → all outputs 0 immediately. A new iStart then produces CLEAR with oEncReset=1, and a correct result for the new block.

Source files
------------

// File: rtl/fixed_order_selector_pkg.sv
// flac_fixed_pkg: shared state encoding, order constants and residual magnitude helper
package flac_fixed_pkg;
  localparam int MAX_FIXED_ORDER = 4;
  localparam int NUM_FIXED_ORDERS = 5;
  localparam int SAMPLE_W = 16;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_FLUSH, S_COMPARE, S_DONE} state_t;
  // 17-bit magnitude so that the most negative residual maps to +32768
  function automatic logic [SAMPLE_W:0] abs17(input logic signed [SAMPLE_W-1:0] r);
    return r[SAMPLE_W-1] ? {1'b0, ~r} + 1'b1 : {1'b0, r};
  endfunction
endpackage

// File: rtl/fixed_order_selector_if.sv
// fixed_order_selector_if: block handshake, encoder-bank control and result bus
interface fixed_order_selector_if #(parameter int SUM_W = 32);
  import flac_fixed_pkg::*;
  logic iStart;
  logic [15:0] iBlockSize;
  logic iValid;
  logic oReady;
  logic oEncEnable;
  logic oEncReset;
  logic signed [SAMPLE_W-1:0] iResidual0, iResidual1, iResidual2, iResidual3, iResidual4;
  logic oBusy;
  logic oDone;
  logic [2:0] oBestOrder;
  logic [SUM_W-1:0] oBestSum;
  modport master (
    output iStart, iBlockSize, iValid, iResidual0, iResidual1, iResidual2, iResidual3, iResidual4,
    input oReady, oEncEnable, oEncReset, oBusy, oDone, oBestOrder, oBestSum
  );
  modport slave (
    input iStart, iBlockSize, iValid, iResidual0, iResidual1, iResidual2, iResidual3, iResidual4,
    output oReady, oEncEnable, oEncReset, oBusy, oDone, oBestOrder, oBestSum
  );
endinterface

// File: rtl/fixed_order_selector_abs_sum.sv
// abs_sum_accumulator: saturating sum of |residual| for one order, skipping its warm-up samples
module abs_sum_accumulator import flac_fixed_pkg::*; #(
  parameter int ORDER = 0,
  parameter int SUM_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear_i,
  input  logic                       en_i,
  input  logic [15:0]                idx_i,
  input  logic signed [SAMPLE_W-1:0] residual_i,
  output logic [SUM_W-1:0]           sum_o
);
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W:0] ext;
  assign ext = {1'b0, sum_q} + (SUM_W+1)'(abs17(residual_i));
  // samples below the order index are predictor warm-up and never count; the carry bit pins the sum at all-ones
  always_comb sum_d = clear_i ? '0 : !(en_i && idx_i >= 16'(ORDER)) ? sum_q : ext[SUM_W] ? '1 : ext[SUM_W-1:0];
  // accumulator register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sum_q <= '0;
    else sum_q <= sum_d;
  assign sum_o = sum_q;
endmodule

// File: rtl/fixed_order_selector.sv
// fixed_order_selector: sequences the fixed-encoder bank over a block and picks the order with least |residual|
module fixed_order_selector import flac_fixed_pkg::*; #(
  parameter int LATENCY = 8,
  parameter int SUM_W = 32
) (
  input logic iClock,
  input logic iReset_n,
  fixed_order_selector_if.slave bus
);
  state_t state_q;
  logic [16:0] n_q, cnt_q, m_q;
  logic [7:0] tmr_q;
  logic [2:0] scan_q, best_ord_q, out_ord_q;
  logic [SUM_W-1:0] best_sum_q, out_sum_q;
  logic ready_q, enc_rst_q, busy_q, done_q;
  logic enc_en, acc_en, clear;
  logic [15:0] idx;
  logic signed [SAMPLE_W-1:0] res [NUM_FIXED_ORDERS];
  logic [SUM_W-1:0] sum_w [NUM_FIXED_ORDERS];
  logic [SUM_W-1:0] sum_eff [NUM_FIXED_ORDERS];
  assign enc_en = (state_q == S_RUN && bus.iValid) || state_q == S_FLUSH;
  assign clear = state_q == S_IDLE && bus.iStart;
  assign acc_en = enc_en && m_q >= 17'(LATENCY + 1);
  assign idx = 16'(m_q - 17'(LATENCY + 1));
  assign res[0] = bus.iResidual0;
  assign res[1] = bus.iResidual1;
  assign res[2] = bus.iResidual2;
  assign res[3] = bus.iResidual3;
  assign res[4] = bus.iResidual4;
  for (genvar k = 0; k < NUM_FIXED_ORDERS; k++) begin : g_ord
    abs_sum_accumulator #(.ORDER(k), .SUM_W(SUM_W)) u_acc (
      .clk(iClock), .rst_n(iReset_n), .clear_i(clear), .en_i(acc_en),
      .idx_i(idx), .residual_i(res[k]), .sum_o(sum_w[k])
    );
    // an order with no post-warm-up samples must lose to every valid order
    assign sum_eff[k] = n_q <= 17'(k) ? '1 : sum_w[k];
  end
  // block sequencer: counters, compare scan and registered outputs
  always_ff @(posedge iClock or negedge iReset_n)
    if (!iReset_n) begin
      state_q <= S_IDLE;
      n_q <= '0;
      cnt_q <= '0;
      m_q <= '0;
      tmr_q <= '0;
      scan_q <= '0;
      best_ord_q <= '0;
      best_sum_q <= '0;
      ready_q <= 1'b0;
      enc_rst_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_ord_q <= '0;
      out_sum_q <= '0;
    end else begin
      done_q <= 1'b0;
      if (enc_en) m_q <= m_q + 1'b1;
      case (state_q)
        S_IDLE: if (bus.iStart) begin
          state_q <= S_CLEAR;
          n_q <= {bus.iBlockSize == 16'd0, bus.iBlockSize};
          cnt_q <= '0;
          m_q <= '0;
          enc_rst_q <= 1'b1;
          busy_q <= 1'b1;
        end
        S_CLEAR: begin
          state_q <= S_RUN;
          enc_rst_q <= 1'b0;
          ready_q <= 1'b1;
        end
        S_RUN: if (bus.iValid) begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q + 1'b1 == n_q) begin
            state_q <= S_FLUSH;
            ready_q <= 1'b0;
            tmr_q <= '0;
          end
        end
        S_FLUSH: begin
          tmr_q <= tmr_q + 1'b1;
          if (tmr_q == 8'(LATENCY)) begin
            state_q <= S_COMPARE;
            scan_q <= '0;
          end
        end
        S_COMPARE: begin
          scan_q <= scan_q + 1'b1;
          if (scan_q == 3'd0 || sum_eff[scan_q] < best_sum_q) begin
            best_sum_q <= sum_eff[scan_q];
            best_ord_q <= scan_q;
          end
          if (scan_q == 3'(MAX_FIXED_ORDER)) state_q <= S_DONE;
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          out_ord_q <= best_ord_q;
          out_sum_q <= best_sum_q;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  assign bus.oReady = ready_q;
  assign bus.oEncEnable = enc_en;
  assign bus.oEncReset = enc_rst_q;
  assign bus.oBusy = busy_q;
  assign bus.oDone = done_q;
  assign bus.oBestOrder = out_ord_q;
  assign bus.oBestSum = out_sum_q;
endmodule

// File: tb/tb_fixed_order_selector.sv
// tb_fixed_order_selector: directed blocks with hand-computed best order/sum on 32- and 16-bit accumulator variants
module tb_fixed_order_selector;
  logic iClock = 1'b0;
  logic iReset_n = 1'b1;
  logic start = 1'b0;
  logic vld = 1'b0;
  logic [15:0] bsz = '0;
  logic signed [15:0] res [5] = '{default: '0};
  int xs [256];
  int nblk = 0;
  int en_cnt = 0;
  int acc_cnt = 0;
  int en_bad = 0;
  int passed = 0;
  int failed = 0;
  int total = 0;
  int coef [5][5] = '{'{1, 0, 0, 0, 0}, '{1, -1, 0, 0, 0}, '{1, -2, 1, 0, 0}, '{1, -3, 3, -1, 0}, '{1, -4, 6, -4, 1}};

  fixed_order_selector_if #(.SUM_W(32)) bus32();
  fixed_order_selector_if #(.SUM_W(16)) bus16();

  fixed_order_selector #(.LATENCY(8), .SUM_W(32)) dut32 (.iClock(iClock), .iReset_n(iReset_n), .bus(bus32.slave));
  fixed_order_selector #(.LATENCY(8), .SUM_W(16)) dut16 (.iClock(iClock), .iReset_n(iReset_n), .bus(bus16.slave));

  assign bus32.iStart = start;
  assign bus32.iBlockSize = bsz;
  assign bus32.iValid = vld;
  assign bus32.iResidual0 = res[0];
  assign bus32.iResidual1 = res[1];
  assign bus32.iResidual2 = res[2];
  assign bus32.iResidual3 = res[3];
  assign bus32.iResidual4 = res[4];
  assign bus16.iStart = start;
  assign bus16.iBlockSize = bsz;
  assign bus16.iValid = vld;
  assign bus16.iResidual0 = res[0];
  assign bus16.iResidual1 = res[1];
  assign bus16.iResidual2 = res[2];
  assign bus16.iResidual3 = res[3];
  assign bus16.iResidual4 = res[4];

  always #5 iClock = ~iClock;

  // encoder-bank model: k-th difference truncated to 16 bits; warm-up and out-of-block slots carry junk
  function automatic logic [15:0] resid(int k, int n);
    int acc;
    acc = 0;
    if (n < 0 || n >= nblk) return 16'h5A5A;
    if (n < k) return 16'h0300 + 16'(n);
    for (int j = 0; j <= k; j++) acc += coef[k][j] * xs[n - j];
    return acc[15:0];
  endfunction

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic en, rs, rdy;
    #1;
    en = bus32.oEncEnable;
    rs = bus32.oEncReset;
    rdy = bus32.oReady;
    if (rdy && en !== vld) en_bad++;
    @(posedge iClock);
    #1;
    if (rs) en_cnt = 0;
    else if (en) en_cnt++;
    if (rdy && vld) acc_cnt++;
    for (int k = 0; k < 5; k++) res[k] = resid(k, en_cnt - 9);
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_ready"}, bus32.oReady, 0);
    chk({tag, "_encen"}, bus32.oEncEnable, 0);
    chk({tag, "_encrst"}, bus32.oEncReset, 0);
    chk({tag, "_busy"}, bus32.oBusy, 0);
    chk({tag, "_done"}, bus32.oDone, 0);
    chk({tag, "_ord32"}, bus32.oBestOrder, 0);
    chk({tag, "_sum32"}, bus32.oBestSum, 0);
    chk({tag, "_ord16"}, bus16.oBestOrder, 0);
    chk({tag, "_sum16"}, bus16.oBestSum, 0);
    chk({tag, "_busy16"}, bus16.oBusy, 0);
  endtask

  task automatic run_block(string tag, int n, bit stall, bit hold_start, int e_ord, longint e32, longint e16);
    int t, last;
    nblk = n;
    acc_cnt = 0;
    start = 1'b1;
    bsz = 16'(n);
    vld = 1'b0;
    tick();
    start = hold_start;
    if (hold_start) bsz = 16'd2;
    chk({tag, "_clear_encrst"}, bus32.oEncReset, 1);
    chk({tag, "_clear_encen"}, bus32.oEncEnable, 0);
    chk({tag, "_clear_busy"}, bus32.oBusy, 1);
    t = 0;
    while (acc_cnt < n && t < 4 * n + 20) begin
      vld = stall ? ((t & 1) == 0) : 1'b1;
      tick();
      t++;
    end
    vld = 1'b0;
    start = 1'b0;
    bsz = 16'(n);
    chk({tag, "_accepts"}, acc_cnt, n);
    last = 0;
    while (!bus32.oDone && last < 40) begin
      start = (last == 14);
      tick();
      last++;
    end
    start = 1'b0;
    chk({tag, "_latency"}, last, 15);
    chk({tag, "_ord32"}, bus32.oBestOrder, e_ord);
    chk({tag, "_sum32"}, bus32.oBestSum, e32);
    chk({tag, "_ord16"}, bus16.oBestOrder, e_ord);
    chk({tag, "_sum16"}, bus16.oBestSum, e16);
    tick();
    chk({tag, "_done_pulse"}, bus32.oDone, 0);
    chk({tag, "_idle_busy"}, bus32.oBusy, 0);
    chk({tag, "_held_ord"}, bus32.oBestOrder, e_ord);
  endtask

  initial begin
    #1 iReset_n = 1'b0;
    #2 chk_zero("reset");
    repeat (2) @(posedge iClock);
    #3 iReset_n = 1'b1;

    for (int i = 0; i < 256; i++) xs[i] = 0;
    run_block("zeros", 16, 1'b0, 1'b0, 0, 0, 0);

    for (int i = 0; i < 16; i++) xs[i] = 100 * i;
    run_block("ramp", 16, 1'b0, 1'b1, 2, 0, 0);

    for (int i = 0; i < 3; i++) xs[i] = 5;
    run_block("const3", 3, 1'b0, 1'b0, 1, 0, 0);

    xs[0] = 7;
    run_block("single", 1, 1'b0, 1'b0, 0, 7, 7);

    for (int i = 0; i < 8; i++) xs[i] = (i % 2 == 0) ? 1 : -1;
    run_block("alt_free", 8, 1'b0, 1'b0, 0, 8, 8);
    en_bad = 0;
    run_block("alt_stall", 8, 1'b1, 1'b0, 0, 8, 8);
    chk("alt_stall_enable", en_bad, 0);

    for (int i = 0; i < 16; i++) xs[i] = 0;
    xs[0] = -32768;
    xs[8] = -32768;
    run_block("impulse", 16, 1'b0, 1'b0, 0, 65536, 65535);

    xs[0] = 32767;
    xs[1] = -32768;
    xs[2] = 32767;
    xs[3] = -32768;
    run_block("extreme", 4, 1'b0, 1'b0, 1, 3, 3);

    for (int i = 0; i < 16; i++) xs[i] = 100 * i;
    nblk = 16;
    acc_cnt = 0;
    start = 1'b1;
    bsz = 16'd16;
    tick();
    start = 1'b0;
    vld = 1'b1;
    repeat (20) tick();
    vld = 1'b0;
    chk("flush_encen", bus32.oEncEnable, 1);
    chk("flush_ready", bus32.oReady, 0);
    #2 iReset_n = 1'b0;
    #1 chk_zero("midreset");
    #2 iReset_n = 1'b1;
    run_block("recover", 16, 1'b0, 1'b0, 2, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
